redmule_tcdm_arbiter: RTL and testbench
=======================================

Name: redmule_tcdm_arbiter

Overview:
- Shares MP 32-bit TCDM banks between two requesters: the RedMulE wide port (MP lanes, all-or-nothing) and the core narrow data port (single 32-bit word).
- Arbitrates per cycle, routes 1-cycle-latency responses back to the owner, and guards against core starvation.
- Keeps saturating traffic counters for perf reporting.
- Sits between redmule_complex and the banked TCDM in the standalone and cluster integrations.

Parameters:
- MP, 8, number of 32-bit banks/lanes (DW = MP*32); power of two, >= 2.
- PRIO_WIDE, 1, 1 = wide port has default priority; 0 = core has default priority.
- MAX_STALL, 4, max consecutive conflict cycles the low-priority requester loses before it is forced to win once; >= 1.
- CNT_W, 32, width of the perf counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear of the perf counters and the stall counter.
- wide_req_i / wide_gnt_o  in/out  1  wide request / grant.
- wide_add_i  in  32  wide byte address.
- wide_wen_i  in  1  1 = read, 0 = write.
- wide_be_i  in  MP*4  wide byte enables.
- wide_data_i  in  MP*32  wide write data.
- wide_r_valid_o / wide_r_data_o  out  1 / MP*32  wide response.
- core_req_i / core_gnt_o  in/out  1  core request / grant.
- core_add_i  in  32  core byte address.
- core_wen_i  in  1  1 = read, 0 = write.
- core_be_i  in  4  core byte enables.
- core_data_i  in  32  core write data.
- core_r_valid_o / core_r_data_o  out  1 / 32  core response.
- mem_req_o  out  MP  per-bank request.
- mem_gnt_i  in  MP  per-bank grant.
- mem_add_o  out  MP*32  per-bank address.
- mem_wen_o  out  MP  per-bank read/write.
- mem_be_o  out  MP*4  per-bank byte enables.
- mem_data_o  out  MP*32  per-bank write data.
- mem_r_valid_i / mem_r_data_i  in  MP / MP*32  per-bank response.
- cnt_wide_o, cnt_core_o, cnt_conflict_o  out  CNT_W each  perf counters.

Behaviour:
- Bank map:
  - Lane ii address = {wide_add_i[31:log2(MP)+2], (log2(MP)+2)'b0} + 4*ii; wide low bits are ignored.
  - Core bank = core_add_i[log2(MP)+1:2].
  - be/data slice ii maps to bank ii.
- mem_gnt_i must not depend combinationally on mem_req_o; the block samples it as bank readiness.
- Wide eligible this cycle = wide_req_i & (&mem_gnt_i). Core eligible = core_req_i & mem_gnt_i[core bank].
- Conflict = both eligible. Without conflict the sole eligible requester wins.
- On conflict the default-priority side (PRIO_WIDE) wins unless stall_q == MAX_STALL; then the other side wins and stall_q returns to 0.
- stall_q increments on each conflict cycle the low-priority side loses. It resets to 0 when:
  - the low-priority side wins;
  - the low-priority side drops its request;
  - clear_i is asserted.
- Winner drives mem_req_o: all MP bits for wide, a one-hot bit for core. Its gnt is asserted the same cycle (combinational). Loser gnt = 0. Requests are never partially issued.
- Response: the owner register records WIDE/CORE/NONE and the core bank on each grant; memory returns r_valid exactly 1 cycle after grant.
  - Next cycle, owner WIDE: wide_r_valid_o = &mem_r_valid_i, wide_r_data_o = mem_r_data_i.
  - Next cycle, owner CORE: core_r_valid_o = mem_r_valid_i[bank_q], core_r_data_o = mem_r_data_i[bank_q].
  - Valid for both reads and writes.
- Counters, each saturating at all-ones and cleared by clear_i (clear has priority):
  - cnt_wide_o +1 per wide grant.
  - cnt_core_o +1 per core grant.
  - cnt_conflict_o +1 per conflict cycle.
- Reset values:
  - All gnt, r_valid and mem_req outputs = 0.
  - mem_add/be/data/r_data outputs = 0.
  - mem_wen_o = all ones.
  - owner = NONE, stall_q = 0, all counters = 0.
- Reset mid-transaction: the pending response is dropped and no r_valid is issued after reset release.
- Idle: mem_req_o = 0 and address/data outputs are held at 0.

Test Plan:
- Reset: assert rst_ni low mid-grant -> all gnt/r_valid/mem_req 0, counters 0; no r_valid after release.
- Core only, MP=8, read 0x1C010008, bank 2 returns 0xDEADBEEF -> mem_req_o=8'h04, core_gnt_o=1; next cycle core_r_valid_o=1, core_r_data_o=0xDEADBEEF; cnt_core_o=1.
- Wide write at 0x1C010024 -> lanes at 0x1C010020+4*ii, mem_req_o=8'hFF. Repeat with mem_gnt_i[5]=0 -> mem_req_o=0, wide_gnt_o=0 until bank 5 is ready.
- PRIO_WIDE=1, MAX_STALL=4, both requesting continuously -> pattern W,W,W,W,C repeating; cnt_conflict_o=5 after 5 cycles; stall_q back to 0 after the core win.
- PRIO_WIDE=0, core requests only bank 3 while bank 3 gnt=0 and wide requests -> wide not eligible either, no grants, no conflict counted.
- Preload cnt_wide_o to all-ones minus 1, issue 3 wide grants -> saturates at all-ones; pulse clear_i -> 0 next cycle.

Source files
------------

// File: rtl/redmule_tcdm_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (wide RedMulE port, narrow core port) and the MP TCDM banks.
// Signal suffixes are seen from the arbiter: the slave modport is the arbiter itself.
interface redmule_tcdm_arbiter_if #(
    parameter int unsigned MP = 8
);
    logic                 wide_req_i;
    logic                 wide_gnt_o;
    logic [31:0]          wide_add_i;
    logic                 wide_wen_i;
    logic [MP*4-1:0]      wide_be_i;
    logic [MP*32-1:0]     wide_data_i;
    logic                 wide_r_valid_o;
    logic [MP*32-1:0]     wide_r_data_o;

    logic                 core_req_i;
    logic                 core_gnt_o;
    logic [31:0]          core_add_i;
    logic                 core_wen_i;
    logic [3:0]           core_be_i;
    logic [31:0]          core_data_i;
    logic                 core_r_valid_o;
    logic [31:0]          core_r_data_o;

    logic [MP-1:0]        mem_req_o;
    logic [MP-1:0]        mem_gnt_i;
    logic [MP*32-1:0]     mem_add_o;
    logic [MP-1:0]        mem_wen_o;
    logic [MP*4-1:0]      mem_be_o;
    logic [MP*32-1:0]     mem_data_o;
    logic [MP-1:0]        mem_r_valid_i;
    logic [MP*32-1:0]     mem_r_data_i;

    modport slave (
        input  wide_req_i, wide_add_i, wide_wen_i, wide_be_i, wide_data_i,
        output wide_gnt_o, wide_r_valid_o, wide_r_data_o,
        input  core_req_i, core_add_i, core_wen_i, core_be_i, core_data_i,
        output core_gnt_o, core_r_valid_o, core_r_data_o,
        output mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o,
        input  mem_gnt_i, mem_r_valid_i, mem_r_data_i
    );

    modport master (
        output wide_req_i, wide_add_i, wide_wen_i, wide_be_i, wide_data_i,
        input  wide_gnt_o, wide_r_valid_o, wide_r_data_o,
        output core_req_i, core_add_i, core_wen_i, core_be_i, core_data_i,
        input  core_gnt_o, core_r_valid_o, core_r_data_o,
        input  mem_req_o, mem_add_o, mem_wen_o, mem_be_o, mem_data_o,
        output mem_gnt_i, mem_r_valid_i, mem_r_data_i
    );
endinterface

// File: rtl/redmule_tcdm_arbiter.sv
// Per-cycle arbiter sharing MP TCDM banks between the all-or-nothing wide port and the single-word core port,
// with anti-starvation for the low-priority side, 1-cycle response routing and saturating perf counters.
module redmule_tcdm_arbiter #(
    parameter int unsigned MP        = 8,
    parameter bit          PRIO_WIDE = 1'b1,
    parameter int unsigned MAX_STALL = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    redmule_tcdm_arbiter_if.slave bus,
    output logic [CNT_W-1:0]     cnt_wide_o,
    output logic [CNT_W-1:0]     cnt_core_o,
    output logic [CNT_W-1:0]     cnt_conflict_o
);
    localparam int unsigned BW  = $clog2(MP);
    localparam int unsigned LSB = BW + 2;
    localparam int unsigned SW  = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_WIDE, OWN_CORE} owner_e;

    owner_e           owner_q;
    logic [BW-1:0]    bank_q;
    logic [BW-1:0]    core_bank;
    logic [SW-1:0]    stall_q, stall_d;
    logic [CNT_W-1:0] cnt_wide_q, cnt_core_q, cnt_conflict_q;
    logic             wide_elig, core_elig, conflict, force_low;
    logic             wide_win, core_win, low_req, low_win;

    assign core_bank = bus.core_add_i[LSB-1:2];

    // rst_ni gates eligibility so grants and bank requests stay low for the whole reset.
    assign wide_elig = rst_ni & bus.wide_req_i & (&bus.mem_gnt_i);
    assign core_elig = rst_ni & bus.core_req_i & bus.mem_gnt_i[core_bank];
    assign conflict  = wide_elig & core_elig;
    assign force_low = conflict & (stall_q == SW'(MAX_STALL));
    assign wide_win  = wide_elig & (~core_elig | (PRIO_WIDE ? ~force_low : force_low));
    assign core_win  = core_elig & ~wide_win;

    assign low_req = PRIO_WIDE ? bus.core_req_i : bus.wide_req_i;
    assign low_win = PRIO_WIDE ? core_win : wide_win;

    always_comb begin
        stall_d = stall_q;
        if (clear_i || !low_req || low_win) begin
            stall_d = '0;
        end else if (conflict) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_comb begin
        bus.wide_gnt_o = wide_win;
        bus.core_gnt_o = core_win;
        bus.mem_req_o  = '0;
        bus.mem_add_o  = '0;
        bus.mem_wen_o  = '1;
        bus.mem_be_o   = '0;
        bus.mem_data_o = '0;
        if (wide_win) begin
            bus.mem_req_o  = '1;
            bus.mem_wen_o  = {MP{bus.wide_wen_i}};
            bus.mem_be_o   = bus.wide_be_i;
            bus.mem_data_o = bus.wide_data_i;
            for (int unsigned ii = 0; ii < MP; ii++) begin
                bus.mem_add_o[ii*32 +: 32] = (bus.wide_add_i & ~32'(MP*4 - 1)) + 32'(ii*4);
            end
        end else if (core_win) begin
            bus.mem_req_o[core_bank]            = 1'b1;
            bus.mem_wen_o[core_bank]            = bus.core_wen_i;
            bus.mem_add_o[core_bank*32 +: 32]   = bus.core_add_i;
            bus.mem_be_o[core_bank*4 +: 4]      = bus.core_be_i;
            bus.mem_data_o[core_bank*32 +: 32]  = bus.core_data_i;
        end
    end

    always_comb begin
        bus.wide_r_valid_o = (owner_q == OWN_WIDE) & (&bus.mem_r_valid_i);
        bus.wide_r_data_o  = (owner_q == OWN_WIDE) ? bus.mem_r_data_i : '0;
        bus.core_r_valid_o = (owner_q == OWN_CORE) & bus.mem_r_valid_i[bank_q];
        bus.core_r_data_o  = (owner_q == OWN_CORE) ? bus.mem_r_data_i[bank_q*32 +: 32] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q        <= OWN_NONE;
            bank_q         <= '0;
            stall_q        <= '0;
            cnt_wide_q     <= '0;
            cnt_core_q     <= '0;
            cnt_conflict_q <= '0;
        end else begin
            owner_q <= wide_win ? OWN_WIDE : (core_win ? OWN_CORE : OWN_NONE);
            if (core_win) begin
                bank_q <= core_bank;
            end
            stall_q <= stall_d;
            if (clear_i) begin
                cnt_wide_q     <= '0;
                cnt_core_q     <= '0;
                cnt_conflict_q <= '0;
            end else begin
                if (wide_win && cnt_wide_q != '1)     cnt_wide_q     <= cnt_wide_q + 1'b1;
                if (core_win && cnt_core_q != '1)     cnt_core_q     <= cnt_core_q + 1'b1;
                if (conflict && cnt_conflict_q != '1) cnt_conflict_q <= cnt_conflict_q + 1'b1;
            end
        end
    end

    assign cnt_wide_o     = cnt_wide_q;
    assign cnt_core_o     = cnt_core_q;
    assign cnt_conflict_o = cnt_conflict_q;
endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Bench for redmule_tcdm_arbiter: two instances (wide-priority/32-bit counters, core-priority/4-bit counters)
// share one stimulus stream and are compared each cycle against a reference model, plus directed vectors.
module tb_redmule_tcdm_arbiter;
    localparam int unsigned MP        = 8;
    localparam int unsigned DW        = MP * 32;
    localparam int unsigned MAX_STALL = 4;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic clear_i = 1'b0;
    always #5 clk_i = ~clk_i;

    redmule_tcdm_arbiter_if #(.MP(MP)) bus0 ();
    redmule_tcdm_arbiter_if #(.MP(MP)) bus1 ();
    logic [31:0] cw0, cc0, cf0;
    logic [3:0]  cw1, cc1, cf1;

    redmule_tcdm_arbiter #(.MP(MP), .PRIO_WIDE(1'b1), .MAX_STALL(MAX_STALL), .CNT_W(32)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .bus(bus0),
        .cnt_wide_o(cw0), .cnt_core_o(cc0), .cnt_conflict_o(cf0)
    );
    redmule_tcdm_arbiter #(.MP(MP), .PRIO_WIDE(1'b0), .MAX_STALL(MAX_STALL), .CNT_W(4)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .bus(bus1),
        .cnt_wide_o(cw1), .cnt_core_o(cc1), .cnt_conflict_o(cf1)
    );

    typedef struct {
        logic            wreq;
        logic [31:0]     wadd;
        logic            wwen;
        logic [4*MP-1:0] wbe;
        logic [DW-1:0]   wdata;
        logic            creq;
        logic [31:0]     cadd;
        logic            cwen;
        logic [3:0]      cbe;
        logic [31:0]     cdata;
        logic [MP-1:0]   mgnt;
        logic [MP-1:0]   mrv;
        logic [DW-1:0]   mrdata;
        logic            clr;
    } stim_t;

    typedef struct packed {
        logic            wg;
        logic            cg;
        logic [MP-1:0]   mreq;
        logic [DW-1:0]   madd;
        logic [MP-1:0]   mwen;
        logic [4*MP-1:0] mbe;
        logic [DW-1:0]   mdata;
        logic            wrv;
        logic [DW-1:0]   wrd;
        logic            crv;
        logic [31:0]     crd;
        logic [63:0]     cw;
        logic [63:0]     cc;
        logic [63:0]     cf;
    } out_t;

    typedef struct {
        logic        wreq;
        logic [31:0] wadd;
        logic        creq;
        logic [31:0] cadd;
        logic [7:0]  mgnt;
        logic [31:0] seed;
        logic [7:0]  e_req;
        logic        e_wg;
        logic        e_cg;
        logic        e_wrv;
        logic        e_crv;
        logic [31:0] e_crd;
    } vec_t;

    stim_t cur;
    int    checks = 0;
    int    errors = 0;

    // Reference model: who owns the pending response, and how many conflicts in a row the
    // low-priority side has lost (it is owed a win once that reaches MAX_STALL).
    int              m_own [2];
    int              m_bank[2];
    int              m_loss[2];
    longint unsigned m_cw[2], m_cc[2], m_cf[2];
    longint unsigned cmax[2] = '{64'hFFFF_FFFF, 64'hF};
    bit              prio[2] = '{1'b1, 1'b0};

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_own[p] = 0; m_bank[p] = 0; m_loss[p] = 0;
            m_cw[p] = 0; m_cc[p] = 0; m_cf[p] = 0;
        end
    endtask

    task automatic idle();
        cur.wreq = 1'b0; cur.wadd = '0; cur.wwen = 1'b1; cur.wbe = '1; cur.wdata = '0;
        cur.creq = 1'b0; cur.cadd = '0; cur.cwen = 1'b1; cur.cbe = '1; cur.cdata = '0;
        cur.mgnt = '1; cur.mrv = '1; cur.mrdata = '0; cur.clr = 1'b0;
    endtask

    task automatic drive();
        bus0.wide_req_i = cur.wreq; bus1.wide_req_i = cur.wreq;
        bus0.wide_add_i = cur.wadd; bus1.wide_add_i = cur.wadd;
        bus0.wide_wen_i = cur.wwen; bus1.wide_wen_i = cur.wwen;
        bus0.wide_be_i = cur.wbe; bus1.wide_be_i = cur.wbe;
        bus0.wide_data_i = cur.wdata; bus1.wide_data_i = cur.wdata;
        bus0.core_req_i = cur.creq; bus1.core_req_i = cur.creq;
        bus0.core_add_i = cur.cadd; bus1.core_add_i = cur.cadd;
        bus0.core_wen_i = cur.cwen; bus1.core_wen_i = cur.cwen;
        bus0.core_be_i = cur.cbe; bus1.core_be_i = cur.cbe;
        bus0.core_data_i = cur.cdata; bus1.core_data_i = cur.cdata;
        bus0.mem_gnt_i = cur.mgnt; bus1.mem_gnt_i = cur.mgnt;
        bus0.mem_r_valid_i = cur.mrv; bus1.mem_r_valid_i = cur.mrv;
        bus0.mem_r_data_i = cur.mrdata; bus1.mem_r_data_i = cur.mrdata;
        clear_i = cur.clr;
    endtask

    task automatic sample(input int p, output out_t o);
        o = '0;
        if (p == 0) begin
            o.wg = bus0.wide_gnt_o; o.cg = bus0.core_gnt_o; o.mreq = bus0.mem_req_o;
            o.madd = bus0.mem_add_o; o.mwen = bus0.mem_wen_o; o.mbe = bus0.mem_be_o;
            o.mdata = bus0.mem_data_o; o.wrv = bus0.wide_r_valid_o; o.wrd = bus0.wide_r_data_o;
            o.crv = bus0.core_r_valid_o; o.crd = bus0.core_r_data_o;
            o.cw = 64'(cw0); o.cc = 64'(cc0); o.cf = 64'(cf0);
        end else begin
            o.wg = bus1.wide_gnt_o; o.cg = bus1.core_gnt_o; o.mreq = bus1.mem_req_o;
            o.madd = bus1.mem_add_o; o.mwen = bus1.mem_wen_o; o.mbe = bus1.mem_be_o;
            o.mdata = bus1.mem_data_o; o.wrv = bus1.wide_r_valid_o; o.wrd = bus1.wide_r_data_o;
            o.crv = bus1.core_r_valid_o; o.crd = bus1.core_r_data_o;
            o.cw = 64'(cw1); o.cc = 64'(cc1); o.cf = 64'(cf1);
        end
    endtask

    task automatic model_check_update(input int p);
        out_t  a, e;
        logic  we, ce, conflict, wwin, cwin, low_req, low_won;
        int    b;
        string pf;
        pf = $sformatf("d%0d.", p);
        sample(p, a);
        b  = int'(cur.cadd[4:2]);
        we = cur.wreq && (cur.mgnt == '1);
        ce = cur.creq && cur.mgnt[b];
        conflict = we && ce;
        if (conflict) wwin = prio[p] ? (m_loss[p] != MAX_STALL) : (m_loss[p] == MAX_STALL);
        else          wwin = we;
        cwin = ce && !wwin;

        e = '0;
        e.mwen = '1;
        e.wg = wwin;
        e.cg = cwin;
        if (wwin) begin
            e.mreq = '1; e.mwen = {MP{cur.wwen}}; e.mbe = cur.wbe; e.mdata = cur.wdata;
            for (int i = 0; i < MP; i++) e.madd[i*32 +: 32] = (cur.wadd & ~32'h1F) + 32'(4*i);
        end else if (cwin) begin
            e.mreq[b] = 1'b1; e.mwen[b] = cur.cwen; e.mbe[b*4 +: 4] = cur.cbe;
            e.mdata[b*32 +: 32] = cur.cdata; e.madd[b*32 +: 32] = cur.cadd;
        end
        if (m_own[p] == 1) begin
            e.wrv = &cur.mrv; e.wrd = cur.mrdata;
        end else if (m_own[p] == 2) begin
            e.crv = cur.mrv[m_bank[p]]; e.crd = cur.mrdata[m_bank[p]*32 +: 32];
        end
        e.cw = m_cw[p]; e.cc = m_cc[p]; e.cf = m_cf[p];

        chk({pf, "wide_gnt"}, DW'(a.wg), DW'(e.wg));
        chk({pf, "core_gnt"}, DW'(a.cg), DW'(e.cg));
        chk({pf, "mem_req"}, DW'(a.mreq), DW'(e.mreq));
        chk({pf, "mem_add"}, a.madd, e.madd);
        chk({pf, "mem_wen"}, DW'(a.mwen), DW'(e.mwen));
        chk({pf, "mem_be"}, DW'(a.mbe), DW'(e.mbe));
        chk({pf, "mem_data"}, a.mdata, e.mdata);
        chk({pf, "wide_r_valid"}, DW'(a.wrv), DW'(e.wrv));
        chk({pf, "wide_r_data"}, a.wrd, e.wrd);
        chk({pf, "core_r_valid"}, DW'(a.crv), DW'(e.crv));
        chk({pf, "core_r_data"}, DW'(a.crd), DW'(e.crd));
        chk({pf, "cnt_wide"}, DW'(a.cw), DW'(e.cw));
        chk({pf, "cnt_core"}, DW'(a.cc), DW'(e.cc));
        chk({pf, "cnt_conflict"}, DW'(a.cf), DW'(e.cf));

        m_own[p] = wwin ? 1 : (cwin ? 2 : 0);
        if (cwin) m_bank[p] = b;
        low_req = prio[p] ? cur.creq : cur.wreq;
        low_won = prio[p] ? cwin : wwin;
        if (cur.clr || !low_req || low_won) m_loss[p] = 0;
        else if (conflict)                   m_loss[p]++;
        if (cur.clr) begin
            m_cw[p] = 0; m_cc[p] = 0; m_cf[p] = 0;
        end else begin
            if (wwin && m_cw[p] < cmax[p])     m_cw[p]++;
            if (cwin && m_cc[p] < cmax[p])     m_cc[p]++;
            if (conflict && m_cf[p] < cmax[p]) m_cf[p]++;
        end
    endtask

    task automatic settle();
        drive();
        #3;
    endtask

    task automatic advance();
        for (int p = 0; p < 2; p++) model_check_update(p);
        @(posedge clk_i);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".d0.mem_req"}, DW'(bus0.mem_req_o), '0);
        chk({tag, ".d1.mem_req"}, DW'(bus1.mem_req_o), '0);
        chk({tag, ".d0.gnt"}, DW'({bus0.wide_gnt_o, bus0.core_gnt_o}), '0);
        chk({tag, ".d1.gnt"}, DW'({bus1.wide_gnt_o, bus1.core_gnt_o}), '0);
        chk({tag, ".d0.r_valid"}, DW'({bus0.wide_r_valid_o, bus0.core_r_valid_o}), '0);
        chk({tag, ".d1.r_valid"}, DW'({bus1.wide_r_valid_o, bus1.core_r_valid_o}), '0);
        chk({tag, ".d0.mem_wen"}, DW'(bus0.mem_wen_o), DW'(8'hFF));
        chk({tag, ".d0.mem_add"}, bus0.mem_add_o, '0);
        chk({tag, ".d0.counters"}, DW'({cw0, cc0, cf0}), '0);
        chk({tag, ".d1.counters"}, DW'({cw1, cc1, cf1}), '0);
    endtask

    vec_t vt[10];

    initial begin
        //          wreq  wadd          creq  cadd          mgnt   seed          e_req  wg    cg    wrv   crv   crd
        vt[0] = '{1'b0, 32'h0,        1'b1, 32'h1C010008, 8'hFF, 32'h0,        8'h04, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0,        1'b0, 32'h0,        8'hFF, 32'hDEADBEED, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[2] = '{1'b1, 32'h1C010024, 1'b0, 32'h0,        8'hFF, 32'h0,        8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[3] = '{1'b1, 32'h1C010024, 1'b0, 32'h0,        8'hDF, 32'h0,        8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[4] = '{1'b1, 32'h1C010024, 1'b0, 32'h0,        8'hDF, 32'h0,        8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[5] = '{1'b1, 32'h1C010024, 1'b0, 32'h0,        8'hFF, 32'h0,        8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[6] = '{1'b1, 32'h1C010040, 1'b1, 32'h1C01000C, 8'hFF, 32'h0,        8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[7] = '{1'b0, 32'h0,        1'b1, 32'h1C01000C, 8'hF7, 32'h0,        8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[8] = '{1'b0, 32'h0,        1'b1, 32'h1C01000C, 8'hFF, 32'h100,      8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[9] = '{1'b0, 32'h0,        1'b0, 32'h0,        8'hFF, 32'h11111110, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11111113};

        model_reset();
        idle();
        cur.wreq = 1'b1;
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outputs("por");
        rst_ni = 1'b1;
        idle();
        step();

        // Directed table on the wide-priority instance.
        for (int k = 0; k < 10; k++) begin
            idle();
            cur.wreq = vt[k].wreq; cur.wadd = vt[k].wadd; cur.wwen = 1'b0;
            cur.creq = vt[k].creq; cur.cadd = vt[k].cadd; cur.cwen = 1'b1;
            cur.mgnt = vt[k].mgnt;
            for (int i = 0; i < MP; i++) cur.mrdata[i*32 +: 32] = vt[k].seed + 32'(i);
            settle();
            chk($sformatf("vec%0d.mem_req", k), DW'(bus0.mem_req_o), DW'(vt[k].e_req));
            chk($sformatf("vec%0d.wide_gnt", k), DW'(bus0.wide_gnt_o), DW'(vt[k].e_wg));
            chk($sformatf("vec%0d.core_gnt", k), DW'(bus0.core_gnt_o), DW'(vt[k].e_cg));
            chk($sformatf("vec%0d.wide_r_valid", k), DW'(bus0.wide_r_valid_o), DW'(vt[k].e_wrv));
            chk($sformatf("vec%0d.core_r_valid", k), DW'(bus0.core_r_valid_o), DW'(vt[k].e_crv));
            chk($sformatf("vec%0d.core_r_data", k), DW'(bus0.core_r_data_o), DW'(vt[k].e_crd));
            advance();
        end

        // Continuous contention: W,W,W,W,C for wide priority; C,C,C,C,W for core priority.
        idle(); cur.clr = 1'b1; step();
        for (int k = 0; k < 10; k++) begin
            idle();
            cur.wreq = 1'b1; cur.wadd = 32'h1C010100 + 32'(k*32);
            cur.creq = 1'b1; cur.cadd = 32'h1C010000 + 32'(4*(k % 8));
            settle();
            if (k == 5) begin
                chk("starve.d0.cnt_conflict", DW'(cf0), DW'(5));
                chk("starve.d0.cnt_wide", DW'(cw0), DW'(4));
                chk("starve.d0.cnt_core", DW'(cc0), DW'(1));
                chk("starve.d1.cnt_conflict", DW'(cf1), DW'(5));
                chk("starve.d1.cnt_wide", DW'(cw1), DW'(1));
            end
            chk($sformatf("starve%0d.d0.wide_gnt", k), DW'(bus0.wide_gnt_o), DW'(k % 5 != 4));
            chk($sformatf("starve%0d.d1.wide_gnt", k), DW'(bus1.wide_gnt_o), DW'(k % 5 == 4));
            advance();
        end

        // Core targets a busy bank while wide also requests: nobody eligible, nothing counted.
        idle(); cur.clr = 1'b1; step();
        for (int k = 0; k < 3; k++) begin
            idle();
            cur.wreq = 1'b1; cur.wadd = 32'h1C010200;
            cur.creq = 1'b1; cur.cadd = 32'h1C01000C; cur.mgnt = 8'hF7;
            settle();
            chk($sformatf("busy%0d.d1.gnt", k), DW'({bus1.wide_gnt_o, bus1.core_gnt_o}), '0);
            chk($sformatf("busy%0d.d1.mem_req", k), DW'(bus1.mem_req_o), '0);
            advance();
        end
        idle();
        settle();
        chk("busy.d1.cnt_conflict", DW'(cf1), '0);
        advance();

        // Saturation of the 4-bit counter, then clear.
        idle(); cur.clr = 1'b1; step();
        for (int k = 0; k < 17; k++) begin
            idle();
            cur.wreq = 1'b1; cur.wadd = $urandom;
            settle();
            if (k == 14) chk("sat.d1.cnt_wide_allones_m1", DW'(cw1), DW'(4'hE));
            advance();
        end
        idle();
        settle();
        chk("sat.d1.cnt_wide", DW'(cw1), DW'(4'hF));
        chk("sat.d0.cnt_wide", DW'(cw0), DW'(17));
        advance();
        idle(); cur.clr = 1'b1; step();
        idle();
        settle();
        chk("clr.d1.cnt_wide", DW'(cw1), '0);
        advance();

        // Reset in the middle of a granted wide access.
        idle();
        cur.wreq = 1'b1; cur.wadd = 32'h1C010040;
        settle();
        chk("mid.d0.wide_gnt_before", DW'(bus0.wide_gnt_o), DW'(1));
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("mid");
        model_reset();
        @(posedge clk_i);
        #1;
        idle();
        drive();
        rst_ni = 1'b1;
        #2;
        chk("mid.d0.no_r_valid", DW'({bus0.wide_r_valid_o, bus0.core_r_valid_o}), '0);
        chk("mid.d1.no_r_valid", DW'({bus1.wide_r_valid_o, bus1.core_r_valid_o}), '0);
        @(posedge clk_i);
        #1;
        step();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cur.wreq  = 1'($urandom_range(0, 1));
            cur.wadd  = $urandom;
            cur.wwen  = 1'($urandom_range(0, 1));
            cur.wbe   = $urandom;
            cur.creq  = 1'($urandom_range(0, 1));
            cur.cadd  = $urandom;
            cur.cwen  = 1'($urandom_range(0, 1));
            cur.cbe   = 4'($urandom);
            cur.cdata = $urandom;
            for (int i = 0; i < MP; i++) begin
                cur.wdata[i*32 +: 32]  = $urandom;
                cur.mrdata[i*32 +: 32] = $urandom;
            end
            cur.mgnt = ($urandom_range(0, 3) != 0) ? '1 : MP'($urandom);
            cur.mrv  = ($urandom_range(0, 9) != 0) ? '1 : MP'($urandom);
            cur.clr  = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
